// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sseg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] dig_idx_t;

endpackage

// File: rtl/bcd11.sv
// Combinational 11-bit binary to 4-digit BCD converter (shift-and-add-3).
module bcd11 (
  input  logic [10:0] bin,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands
);

  logic [26:0] sh;

  always_comb begin
    sh = {16'd0, bin};
    for (int i = 0; i < 11; i++) begin
      if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
      if (sh[18:15] >= 4'd5) sh[18:15] = sh[18:15] + 4'd3;
      if (sh[22:19] >= 4'd5) sh[22:19] = sh[22:19] + 4'd3;
      if (sh[26:23] >= 4'd5) sh[26:23] = sh[26:23] + 4'd3;
      sh = sh << 1;
    end
  end

  assign ones      = sh[14:11];
  assign tens      = sh[18:15];
  assign hundreds  = sh[22:19];
  assign thousands = sh[26:23];

endmodule

// File: rtl/sseg_decoder.sv
// BCD digit to active-low gfedcba segment pattern; non-decimal codes go dark.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// 4-digit multiplexed seven-segment controller; new values are committed
// only at frame boundaries so a frame never mixes old and new digits.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] in_val,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  dig_idx_t         dig;
  logic [10:0]      pend_val;
  logic             pend;
  logic [10:0]      shown;
  logic             boundary;

  assign boundary = (dig == 2'd3) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dig <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the boundary cycle re-arms pend after the old value commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend     <= 1'b0;
      shown    <= '0;
    end else begin
      if (boundary && pend) shown <= pend_val;
      if (load) begin
        pend_val <= in_val;
        pend     <= 1'b1;
      end else if (boundary) begin
        pend <= 1'b0;
      end
    end
  end

  logic [3:0] d_ones, d_tens, d_hund, d_thou;

  bcd11 u_bcd (
    .bin       (shown),
    .ones      (d_ones),
    .tens      (d_tens),
    .hundreds  (d_hund),
    .thousands (d_thou)
  );

  dig_idx_t   dig_eff;
  logic [3:0] bcd_sel;
  logic       blank;

  // While rst is held the display shows a lit zero on the ones digit.
  always_comb begin
    dig_eff = rst ? 2'd0 : dig;
    bcd_sel = 4'd0;
    blank   = 1'b0;
    if (!rst) begin
      unique case (dig)
        2'd0: bcd_sel = d_ones;
        2'd1: bcd_sel = d_tens;
        2'd2: bcd_sel = d_hund;
        2'd3: bcd_sel = d_thou;
        default: bcd_sel = 4'd0;
      endcase
      if (BLANK_LZ) begin
        unique case (dig)
          2'd1: blank = (d_thou == 4'd0) && (d_hund == 4'd0) && (d_tens == 4'd0);
          2'd2: blank = (d_thou == 4'd0) && (d_hund == 4'd0);
          2'd3: blank = (d_thou == 4'd0);
          default: blank = 1'b0;
        endcase
      end
    end
  end

  sseg_decoder u_dec (
    .bcd (bcd_sel),
    .seg (seg)
  );

  assign an         = blank ? AN_OFF : ~(4'b0001 << dig_eff);
  assign dp         = 1'b1;
  assign frame_done = boundary && !rst;
  assign load_ack   = boundary && pend && !rst;

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexed 4-digit seven-segment display controller for the 11-bit binary-to-BCD path. It accepts a binary value through a load strobe and holds it in a pending register. At each frame boundary it commits that value to a display register, which feeds the `bcd11` converter. It then scans the four BCD digits onto the shared segment bus, one anode at a time, with optional leading-zero blanking. It sits between user logic and the board's common-anode display.

## Interface
- `REFRESH_DIV`, 100000, clock cycles each digit is lit (≥2); frame = 4·REFRESH_DIV cycles
- `BLANK_LZ`, 1, 1 = suppress leading zeros; 0 = always show 4 digits
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `in_val`  in  11  binary value to display (0–2047)
- `load`  in  1  1-cycle strobe; capture `in_val` into pending register
- `load_ack`  out  1  1-cycle pulse when a pending value is committed to display
- `frame_done`  out  1  1-cycle pulse on last cycle of digit 3
- `an`  out  4  anode enables, active-low; `an[0]` = ones … `an[3]` = thousands
- `seg`  out  7  segments `gfedcba`, active-low
- `dp`  out  1  decimal point, active-low, constant 1 (off)

## Operation
- Registers:
  - `cnt`: 0..REFRESH_DIV-1.
  - `dig`: 0..3.
  - `pend_val[10:0]` and `pend` flag.
  - `shown[10:0]`.
- Refresh counter:
  - `cnt` increments every cycle.
  - At REFRESH_DIV-1, `cnt` wraps to 0 and `dig` advances 0→1→2→3→0.
- Frame boundary: the cycle where `dig`=3 and `cnt`=REFRESH_DIV-1. On that cycle:
  - `frame_done`=1.
  - If `pend`=1 (value before this edge): `shown`←`pend_val`, `pend`←0, `load_ack`=1.
- Load:
  - `load`=1 sets `pend_val`←`in_val` and `pend`←1.
  - A second load before the boundary overwrites `pend_val`; latest value wins, with one `load_ack`.
- Load coincident with a boundary while `pend`=1:
  - The old `pend_val` commits.
  - The new value is captured and `pend` stays 1 for the next frame.
- Load coincident with a boundary while `pend`=0: the value commits at the following boundary.
- `shown` drives `bcd11`. Digit select muxes ones/tens/hundreds/thousands by `dig`, and the selected digit goes through the decoder.
- `an` = one-hot-low of `dig`, forced to 4'b1111 for a blanked digit.
- Blanking (BLANK_LZ=1):
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked.
- Decoder, seg `gfedcba`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other code = 1111111.

## Timing
- `an`, `seg`, `dp` are combinational from registered `dig`/`shown`. They change in the same cycle `dig` or `shown` updates, with no extra pipeline stage.
- Load-to-display latency is 1 to 4·REFRESH_DIV cycles, always landing at a frame boundary; no mid-frame tearing.
- `load_ack` and `frame_done` are registered-state decodes, high for exactly 1 cycle.
- Reset values: `cnt`=0, `dig`=0, `shown`=0, `pend`=0, `pend_val`=0.
- Outputs during reset: `an`=1110, `seg`=1000000, `dp`=1, `load_ack`=0, `frame_done`=0.
- `rst` mid-frame discards any pending value (no `load_ack`) and restarts at digit 0 on the next cycle.
- `rst` and `load` in the same cycle: reset wins, nothing is captured.

## Structure
- Package `sseg_pkg`:
  - digit-code → segment constants (`SEG_0`..`SEG_9`, `SEG_OFF`)
  - `AN_OFF` = 4'b1111
  - digit index typedef (2-bit).
- Sub-module `sseg_decoder` (4-bit BCD in → 7-bit seg out, combinational).
- Existing `bcd11` is instantiated unchanged.
- Counter, pending logic and digit mux stay in the top level.

## Test plan
All scenarios use REFRESH_DIV=4 (frame = 16 cycles), BLANK_LZ=1 unless noted.
- Reset, no load:
  - `an`=1110, `seg`=1000000, `dp`=1.
  - `frame_done` pulses at cycle 15, 31, …; `load_ack` never asserts.
  - Digits 1–3 show `an`=1111.
- Load 1234 at cycle 5:
  - Display unchanged until cycle 15, where `load_ack`=1.
  - Next frame shows ones seg=0011001 (4), tens 0110000 (3), hundreds 0100100 (2), thousands 1111001 (1), with `an` 1110/1101/1011/0111.
- Load 7:
  - Only the ones slot lights, seg=1111000.
  - Tens/hundreds/thousands slots have `an`=1111.
  - Repeat with BLANK_LZ=0: all four lit, showing 0,0,0,7.
- Load 100 at cycle 3, then 2047 at cycle 9, in one frame:
  - One `load_ack` at cycle 15.
  - Display shows 2,0,4,7; 100 never appears.
- Load 500 at cycle 10, then load 42 exactly at boundary cycle 15:
  - 500 commits at 15 with `load_ack`.
  - 42 commits at 31 with a second `load_ack`.
- Load 999, `rst` at cycle 8:
  - No `load_ack`; display stays 0.
  - `dig` is 0 on cycle 9.
  - `frame_done` next at cycle 8+16.
